lock_sequencer: RTL and testbench



---
 rtl/lock_pkg.sv | 20 ++
 rtl/lock_timer.sv | 31 +++
 rtl/lock_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encodings and key constants for the safe-lock code-entry controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    PROGRAM  = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  localparam logic [3:0] KEY_CLR  = 4'hA;
  localparam logic [3:0] KEY_ENT  = 4'hB;
  localparam logic [3:0] KEY_PROG = 4'hC;

  function automatic logic is_digit(logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable 32-bit down-counter; done is high for the one cycle the count sits at zero.
module lock_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] count_q;
  logic        running_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (load) begin
      count_q   <= load_val;
      running_q <= 1'b1;
    end else if (running_q) begin
      if (count_q == '0) begin
        running_q <= 1'b0;
      end else begin
        count_q <= count_q - 32'd1;
      end
    end
  end

  assign done = running_q && (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Code-entry controller: collects passcode digits, checks them, times unlock and
// lockout windows, and lets an unlocked user program a new passcode.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 4,
  parameter int unsigned           MAX_ATTEMPTS   = 3,
  parameter int unsigned           UNLOCK_CYCLES  = 250000000,
  parameter int unsigned           LOCKOUT_CYCLES = 1500000000,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlock,
  output logic       locked_out,
  output logic       err,
  output logic       prog_done,
  output logic [2:0] digit_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned CodeW  = CODE_LEN * 4;
  localparam int unsigned CntW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW  = $clog2(MAX_ATTEMPTS + 1);

  state_e             state_q, state_d;
  logic [CodeW-1:0]   code_buf_q, code_buf_d;
  logic [CodeW-1:0]   stored_q, stored_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FailW-1:0]   fail_q, fail_d;
  logic               err_d, prog_done_d;
  logic               tmr_load, tmr_done;
  logic [31:0]        tmr_val;
  logic               full, match;

  assign full  = (cnt_q == CntW'(CODE_LEN));
  assign match = full && (code_buf_q == stored_q);

  lock_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    code_buf_d  = code_buf_q;
    cnt_d       = cnt_q;
    stored_d    = stored_q;
    fail_d      = fail_q;
    err_d       = 1'b0;
    prog_done_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (!full) begin
              code_buf_d = (code_buf_q << 4) | CodeW'(key_code);
              cnt_d      = cnt_q + CntW'(1);
            end
          end else if (key_code == KEY_CLR) begin
            code_buf_d = '0;
            cnt_d      = '0;
          end else if (key_code == KEY_ENT) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        code_buf_d = '0;
        cnt_d      = '0;
        if (match) begin
          state_d  = UNLOCKED;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = 32'(UNLOCK_CYCLES - 1);
        end else begin
          err_d = 1'b1;
          if (fail_q == FailW'(MAX_ATTEMPTS - 1)) begin
            state_d  = LOCKOUT;
            fail_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = 32'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ENTRY;
            fail_d  = fail_q + FailW'(1);
          end
        end
      end
      UNLOCKED: begin
        if (tmr_done) begin
          state_d = ENTRY;
        end else if (key_valid && key_code == KEY_ENT) begin
          state_d = ENTRY;
        end else if (key_valid && key_code == KEY_PROG) begin
          // Timer is deliberately not reloaded: programming shares the unlock window.
          state_d    = PROGRAM;
          code_buf_d = '0;
          cnt_d      = '0;
        end
      end
      PROGRAM: begin
        if (tmr_done) begin
          state_d    = ENTRY;
          code_buf_d = '0;
          cnt_d      = '0;
        end else if (key_valid) begin
          if (is_digit(key_code)) begin
            if (!full) begin
              code_buf_d = (code_buf_q << 4) | CodeW'(key_code);
              cnt_d      = cnt_q + CntW'(1);
            end
          end else if (key_code == KEY_CLR) begin
            state_d    = ENTRY;
            code_buf_d = '0;
            cnt_d      = '0;
          end else if (key_code == KEY_ENT) begin
            code_buf_d = '0;
            cnt_d      = '0;
            if (full) begin
              stored_d    = code_buf_q;
              prog_done_d = 1'b1;
              state_d     = ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      LOCKOUT: begin
        if (tmr_done) state_d = ENTRY;
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTRY;
      code_buf_q <= '0;
      stored_q   <= DEFAULT_CODE;
      cnt_q      <= '0;
      fail_q     <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      err        <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_buf_q <= code_buf_d;
      stored_q   <= stored_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      unlock     <= (state_d == UNLOCKED) || (state_d == PROGRAM);
      locked_out <= (state_d == LOCKOUT);
      err        <= err_d;
      prog_done  <= prog_done_d;
    end
  end

  assign state_o   = state_q;
  assign digit_cnt = 3'(cnt_q);

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios with literal expectations, then random
// keys, all cross-checked every cycle against a queue-based behavioural model.
module tb_lock_sequencer;

  localparam int unsigned UNL = 20;
  localparam int unsigned LCK = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlock, locked_out, err, prog_done;
  logic [2:0] digit_cnt, state_o;

  always #5 clk = ~clk;

  lock_sequencer #(
    .CODE_LEN       (4),
    .MAX_ATTEMPTS   (3),
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LCK),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .unlock     (unlock),
    .locked_out (locked_out),
    .err        (err),
    .prog_done  (prog_done),
    .digit_cnt  (digit_cnt),
    .state_o    (state_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode number, digit queue, cycles left in the timed modes.
  int m_state, m_fail, m_left;
  int m_stored[4];
  int m_q[$];
  bit m_err, m_pd;

  task automatic model_reset();
    m_state = 0;
    m_q.delete();
    m_fail = 0;
    m_left = 0;
    m_stored = '{1, 2, 3, 4};
    m_err = 0;
    m_pd = 0;
  endtask

  task automatic model_step(bit r, bit kv, int kc);
    bit match;
    m_err = 0;
    m_pd = 0;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (kv) begin
        if (kc <= 9) begin
          if (m_q.size() < 4) m_q.push_back(kc);
        end else if (kc == 10) m_q.delete();
        else if (kc == 11) m_state = 1;
      end
      1: begin
        match = (m_q.size() == 4);
        if (match) for (int i = 0; i < 4; i++) if (m_q[i] != m_stored[i]) match = 0;
        m_q.delete();
        if (match) begin
          m_state = 2; m_left = UNL; m_fail = 0;
        end else begin
          m_err = 1;
          if (m_fail == 2) begin
            m_state = 4; m_left = LCK; m_fail = 0;
          end else begin
            m_fail++; m_state = 0;
          end
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_state = 0;
        else if (kv && kc == 11) m_state = 0;
        else if (kv && kc == 12) begin
          m_state = 3; m_q.delete();
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          m_state = 0; m_q.delete();
        end else if (kv) begin
          if (kc <= 9) begin
            if (m_q.size() < 4) m_q.push_back(kc);
          end else if (kc == 10) begin
            m_state = 0; m_q.delete();
          end else if (kc == 11) begin
            if (m_q.size() == 4) begin
              for (int i = 0; i < 4; i++) m_stored[i] = m_q[i];
              m_pd = 1; m_state = 0;
            end else m_err = 1;
            m_q.delete();
          end
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  // Compare process: inputs are stable across posedge (driven on negedge).
  initial begin
    bit r, kv;
    int kc;
    model_reset();
    forever begin
      @(posedge clk);
      r = rst; kv = key_valid; kc = int'(key_code);
      #1;
      model_step(r, kv, kc);
      check("m_unlock", int'(unlock), int'(m_state == 2 || m_state == 3));
      check("m_locked_out", int'(locked_out), int'(m_state == 4));
      check("m_err", int'(err), int'(m_err));
      check("m_prog_done", int'(prog_done), int'(m_pd));
      check("m_digit_cnt", int'(digit_cnt), m_q.size());
      check("m_state", int'(state_o), m_state);
    end
  end

  task automatic press(int kc);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(kc);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter(int a, int b, int c, int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(int s, int budget, string name);
    int n = 0;
    while (int'(state_o) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_o), s);
  endtask

  task automatic unlock_1234(string name);
    enter(1, 2, 3, 4);
    @(negedge clk);
    check(name, int'(unlock), 1);
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", int'(state_o), 0);
    check("reset_unlock", int'(unlock), 0);
    check("reset_dcnt", int'(digit_cnt), 0);

    // Basic unlock, latency and window length
    enter(1, 2, 3, 4);
    check("t1_check_state", int'(state_o), 1);
    check("t1_unlock_early", int'(unlock), 0);
    @(negedge clk);
    check("t1_unlock", int'(unlock), 1);
    n = 0;
    while (unlock && n < 100) begin n++; @(negedge clk); end
    check("t1_unlock_len", n, 20);
    check("t1_after_state", int'(state_o), 0);

    // Three failures -> lockout; keys ignored during lockout
    for (int i = 0; i < 3; i++) begin
      enter(1, 2, 3, 5);
      @(negedge clk);
      check("t2_err", int'(err), 1);
    end
    check("t2_locked", int'(locked_out), 1);
    enter(1, 2, 3, 4);
    check("t2_no_unlock", int'(unlock), 0);
    n = 0;
    while (locked_out && n < 200) begin n++; @(negedge clk); end
    check("t2_lock_rest", n, 40);
    unlock_1234("t2_unlock_after");
    press(11);
    check("t2_relock", int'(state_o), 0);

    // Clear key and overflow digits
    press(1); press(2); press(10);
    check("t3_cleared", int'(digit_cnt), 0);
    unlock_1234("t3_unlock");
    press(11);
    press(1); press(2); press(3); press(4); press(9);
    check("t4_dcnt", int'(digit_cnt), 4);
    press(11);
    @(negedge clk);
    check("t4_unlock", int'(unlock), 1);
    press(11);

    // Short program entry, then timer expiry in PROGRAM
    unlock_1234("t5_unlock");
    press(12);
    check("t5_prog_state", int'(state_o), 3);
    press(5); press(5); press(11);
    check("t5_prog_err", int'(err), 1);
    check("t5_stay_prog", int'(state_o), 3);
    wait_state(0, 40, "t5_expire");
    check("t5_unlock_off", int'(unlock), 0);
    unlock_1234("t5_code_kept");
    press(11);

    // Reset during UNLOCKED and during LOCKOUT
    unlock_1234("t6_unlock");
    pulse_rst();
    check("t6_rst_unlock", int'(unlock), 0);
    check("t6_rst_state", int'(state_o), 0);
    unlock_1234("t6_unlock_again");
    press(11);
    for (int i = 0; i < 3; i++) enter(1, 2, 3, 5);
    @(negedge clk);
    check("t6_locked", int'(locked_out), 1);
    pulse_rst();
    check("t6_rst_locked", int'(locked_out), 0);
    check("t6_rst_state2", int'(state_o), 0);
    unlock_1234("t6_unlock_after_lock");
    press(11);

    // Program a new code
    unlock_1234("t7_unlock");
    press(12);
    press(9); press(8); press(7); press(6); press(11);
    check("t7_prog_done", int'(prog_done), 1);
    check("t7_state", int'(state_o), 0);
    enter(1, 2, 3, 4);
    @(negedge clk);
    check("t7_old_err", int'(err), 1);
    enter(9, 8, 7, 6);
    @(negedge clk);
    check("t7_new_unlock", int'(unlock), 1);
    press(11);

    // Random phase
    for (int it = 0; it < 3000; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) pulse_rst();
      else if (r < 14) enter(m_stored[0], m_stored[1], m_stored[2], m_stored[3]);
      else if (r < 65) press(int'($urandom_range(0, 15)));
      else @(negedge clk);
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
